itram_arbiter: RTL and testbench

//  Sequences and shares the single-port instruction RAM between the fetch path and a program loader (boot/debug writes).

---
 rtl/itram_arbiter_pkg.sv | 16 +
 rtl/itram_arbiter.sv | 141 ++++++++++++++
 tb/tb_itram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/itram_arbiter_pkg.sv
// Shared definitions for the instruction RAM arbiter.
package itram_arbiter_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Fetch sequencer states: no read pending, read in flight, instruction held for stall
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : itram_arbiter_pkg

// File: rtl/itram_arbiter.sv
// Shares the single-port instruction RAM between the fetch path and the program loader,
// sequences fetch reads and holds/discards returned instructions on stall/flush.
module itram_arbiter
  import itram_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LD_MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [XLEN-1:0]    fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_data,
  input  logic               fetch_stall,
  input  logic               flush_flag,
  output logic               misalign_err,
  input  logic               ld_req,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_gnt,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [INSTR_W-1:0] ram_wdata,
  input  logic [INSTR_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(LD_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LD_MAX_BURST);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                 fetch_valid_d;
  logic [INSTR_W-1:0]   fetch_data_d;
  logic                 misalign_d;
  logic                 aligned;
  logic                 fetch_elig;
  logic                 unused_addr_hi;

  // RAM only sees the low address bits of the fetch address
  assign unused_addr_hi = ^fetch_addr[XLEN-1:ADDR_W];

  // FSM state and loader burst counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Returned instruction register and misalignment pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid  <= FALSE;
      fetch_data   <= '0;
      misalign_err <= FALSE;
    end else begin
      fetch_valid  <= fetch_valid_d;
      fetch_data   <= fetch_data_d;
      misalign_err <= misalign_d;
    end
  end

  // Arbitration, RAM port drive, burst accounting and next-state
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    fetch_valid_d = fetch_valid;
    fetch_data_d  = fetch_data;
    fetch_gnt     = FALSE;
    ld_gnt        = FALSE;
    ram_en        = FALSE;
    ram_we        = FALSE;
    ram_addr      = '0;
    ram_wdata     = '0;

    aligned    = (fetch_addr[1:0] == 2'b00);
    misalign_d = fetch_req && !aligned;

    // A held instruction blocks new reads only while the stall persists; the cycle the
    // stall releases may already issue the next read.
    fetch_elig = fetch_req && aligned && !flush_flag &&
                 !((state_q == RD || state_q == HOLD) && fetch_stall);

    if (ld_req && !(fetch_elig && burst_cnt_q == BURST_MAX)) begin
      ld_gnt    = TRUE;
      ram_en    = TRUE;
      ram_we    = TRUE;
      ram_addr  = ld_addr;
      ram_wdata = ld_data;
    end else if (fetch_elig) begin
      fetch_gnt = TRUE;
      ram_en    = TRUE;
      ram_addr  = fetch_addr[ADDR_W-1:0];
    end

    if (fetch_gnt || !fetch_elig) begin
      burst_cnt_d = '0;
    end else if (ld_gnt && burst_cnt_q != BURST_MAX) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        fetch_valid_d = FALSE;
        if (fetch_gnt) state_d = RD;
      end
      RD: begin
        if (flush_flag) begin
          fetch_valid_d = FALSE;
          state_d       = fetch_gnt ? RD : IDLE;
        end else begin
          fetch_valid_d = TRUE;
          fetch_data_d  = ram_rdata;
          if (fetch_stall) state_d = HOLD;
          else             state_d = fetch_gnt ? RD : IDLE;
        end
      end
      HOLD: begin
        if (flush_flag) begin
          fetch_valid_d = FALSE;
          state_d       = IDLE;
        end else if (!fetch_stall) begin
          fetch_valid_d = FALSE;
          state_d       = fetch_gnt ? RD : IDLE;
        end
      end
      default: begin
        fetch_valid_d = FALSE;
        state_d       = IDLE;
      end
    endcase
  end

endmodule : itram_arbiter

// File: tb/tb_itram_arbiter.sv
// Directed bench for itram_arbiter with a behavioural single-port RAM.
module tb_itram_arbiter;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic        flush_flag;
  logic        misalign_err;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_gnt;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  itram_arbiter #(.XLEN(32), .ADDR_W(16), .LD_MAX_BURST(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .fetch_stall  (fetch_stall),
    .flush_flag   (flush_flag),
    .misalign_err (misalign_err),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_gnt       (ld_gnt),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM; read data only changes on read cycles
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[15:2]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[15:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'h0000_0093;
    mem[2]  = 32'h0000_0113;
    mem[4]  = 32'h00A0_0093;
    mem[8]  = 32'h1111_1111;
    mem[16] = 32'h2222_2222;
    ram_rdata   = 32'h0;
    rst         = 1'b0;
    fetch_req   = 1'b0;
    fetch_addr  = 32'h0;
    fetch_stall = 1'b0;
    flush_flag  = 1'b0;
    ld_req      = 1'b0;
    ld_addr     = 16'h0;
    ld_data     = 32'h0;

    // Reset state
    tick; tick;
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_data", fetch_data, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    rst = 1'b1;
    tick;

    // 1: back-to-back fetch of 0x0, 0x4, 0x8
    fetch_req = 1'b1; fetch_addr = 32'h0; settle;
    check("t1_gnt0", 32'(fetch_gnt), 32'h1);
    check("t1_addr0", 32'(ram_addr), 32'h0);
    check("t1_we0", 32'(ram_we), 32'h0);
    tick;
    check("t1_valid_lat", 32'(fetch_valid), 32'h0);
    fetch_addr = 32'h4; settle;
    check("t1_gnt1", 32'(fetch_gnt), 32'h1);
    tick;
    check("t1_valid0", 32'(fetch_valid), 32'h1);
    check("t1_data0", fetch_data, 32'h13);
    fetch_addr = 32'h8; settle;
    check("t1_gnt2", 32'(fetch_gnt), 32'h1);
    tick;
    check("t1_valid1", 32'(fetch_valid), 32'h1);
    check("t1_data1", fetch_data, 32'h93);
    fetch_req = 1'b0; settle;
    check("t1_idle_en", 32'(ram_en), 32'h0);
    tick;
    check("t1_valid2", 32'(fetch_valid), 32'h1);
    check("t1_data2", fetch_data, 32'h113);
    tick;
    check("t1_valid_end", 32'(fetch_valid), 32'h0);

    // 2: read 0x10, stall holds the instruction
    fetch_req = 1'b1; fetch_addr = 32'h10; settle;
    check("t2_gnt", 32'(fetch_gnt), 32'h1);
    tick;
    fetch_addr = 32'h14; fetch_stall = 1'b1; settle;
    check("t2_nogntA", 32'(fetch_gnt), 32'h0);
    tick;
    check("t2_validA", 32'(fetch_valid), 32'h1);
    check("t2_dataA", fetch_data, 32'h00A0_0093);
    settle;
    check("t2_nogntB", 32'(fetch_gnt), 32'h0);
    tick;
    check("t2_validB", 32'(fetch_valid), 32'h1);
    settle;
    check("t2_nogntC", 32'(fetch_gnt), 32'h0);
    tick;
    check("t2_validC", 32'(fetch_valid), 32'h1);
    check("t2_dataC", fetch_data, 32'h00A0_0093);
    fetch_stall = 1'b0; settle;
    check("t2_gnt_release", 32'(fetch_gnt), 32'h1);
    tick;
    check("t2_valid_clr", 32'(fetch_valid), 32'h0);
    fetch_req = 1'b0;
    tick;
    check("t2_valid_next", 32'(fetch_valid), 32'h1);
    check("t2_data_next", fetch_data, 32'h1000_0005);
    tick;
    check("t2_valid_end", 32'(fetch_valid), 32'h0);

    // 3: flush after grant of 0x20
    fetch_req = 1'b1; fetch_addr = 32'h20; settle;
    check("t3_gnt", 32'(fetch_gnt), 32'h1);
    tick;
    flush_flag = 1'b1; fetch_addr = 32'h40; settle;
    check("t3_flush_nognt", 32'(fetch_gnt), 32'h0);
    tick;
    check("t3_flush_valid", 32'(fetch_valid), 32'h0);
    flush_flag = 1'b0; settle;
    check("t3_gnt40", 32'(fetch_gnt), 32'h1);
    check("t3_addr40", 32'(ram_addr), 32'h40);
    tick;
    check("t3_valid_lat", 32'(fetch_valid), 32'h0);
    fetch_req = 1'b0;
    tick;
    check("t3_valid40", 32'(fetch_valid), 32'h1);
    check("t3_data40", fetch_data, 32'h2222_2222);
    tick;

    // 4: continuous loader traffic against a waiting fetch
    fetch_req = 1'b1; fetch_addr = 32'h0;
    ld_req = 1'b1; ld_addr = 16'h0100;
    for (int i = 0; i < 19; i++) begin
      logic exp_f;
      logic exp_v;
      exp_f = ((i % 9) == 8);
      exp_v = ((i % 9) == 0) && (i != 0);
      ld_data = 32'hA500_0000 + 32'(i);
      settle;
      check($sformatf("t4_ld_gnt[%0d]", i), 32'(ld_gnt), 32'(!exp_f));
      check($sformatf("t4_fetch_gnt[%0d]", i), 32'(fetch_gnt), 32'(exp_f));
      if (!exp_f) check($sformatf("t4_wdata[%0d]", i), ram_wdata, 32'hA500_0000 + 32'(i));
      tick;
      check($sformatf("t4_valid[%0d]", i), 32'(fetch_valid), 32'(exp_v));
    end
    check("t4_data", fetch_data, 32'h13);
    fetch_req = 1'b0; ld_req = 1'b0;
    tick;

    // 5: write to 0x8 while a read of 0x8 is in flight
    fetch_req = 1'b1; fetch_addr = 32'h8; settle;
    check("t5_gnt", 32'(fetch_gnt), 32'h1);
    tick;
    fetch_req = 1'b0; ld_req = 1'b1; ld_addr = 16'h0008; ld_data = 32'hDEAD_BEEF; settle;
    check("t5_ld_gnt", 32'(ld_gnt), 32'h1);
    check("t5_we", 32'(ram_we), 32'h1);
    check("t5_waddr", 32'(ram_addr), 32'h8);
    tick;
    check("t5_valid_old", 32'(fetch_valid), 32'h1);
    check("t5_data_old", fetch_data, 32'h113);
    ld_req = 1'b0; fetch_req = 1'b1; settle;
    check("t5_gnt2", 32'(fetch_gnt), 32'h1);
    tick;
    fetch_req = 1'b0;
    tick;
    check("t5_valid_new", 32'(fetch_valid), 32'h1);
    check("t5_data_new", fetch_data, 32'hDEAD_BEEF);
    tick;

    // 6: misaligned fetch
    fetch_req = 1'b1; fetch_addr = 32'h6; settle;
    check("t6_nognt", 32'(fetch_gnt), 32'h0);
    check("t6_ram_en", 32'(ram_en), 32'h0);
    tick;
    check("t6_err1", 32'(misalign_err), 32'h1);
    tick;
    check("t6_err2", 32'(misalign_err), 32'h1);
    fetch_req = 1'b0;
    tick;
    check("t6_err_clr", 32'(misalign_err), 32'h0);

    // 6b: reset while a read is in flight
    fetch_req = 1'b1; fetch_addr = 32'h0; settle;
    check("t6_rd_gnt", 32'(fetch_gnt), 32'h1);
    tick;
    rst = 1'b0; fetch_req = 1'b0; settle;
    check("t6_rst_valid", 32'(fetch_valid), 32'h0);
    check("t6_rst_data", fetch_data, 32'h0);
    check("t6_rst_err", 32'(misalign_err), 32'h0);
    check("t6_rst_gnt", 32'(fetch_gnt), 32'h0);
    check("t6_rst_ram_en", 32'(ram_en), 32'h0);
    tick; tick;
    rst = 1'b1;
    tick;
    check("t6_noreplay_valid", 32'(fetch_valid), 32'h0);
    check("t6_noreplay_data", fetch_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_itram_arbiter
